// File: rtl/conv_window_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_sequencer_if
//  Description : Request/status bundle between the AHB slave front end and
//                the 3x3 convolver window sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_window_sequencer_if #(
  parameter int IMG_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);

  // Requests and datapath status toward the sequencer
  logic          sample_load_en;
  logic          new_row;
  logic          coeff_load_en;
  logic [FW-1:0] fifo_count;
  logic          result_ready;

  // Control and status from the sequencer
  logic          modwait;
  logic          sample_shift;
  logic          convolve_en;
  logic          coeff_ld;
  logic [1:0]    coeff_sel;
  logic          fifo_wenable;
  logic [CW-1:0] col_idx;
  logic          err;

  // Requester side (AHB slave front end)
  modport master (
    output sample_load_en, new_row, coeff_load_en, fifo_count, result_ready,
    input  modwait, sample_shift, convolve_en, coeff_ld, coeff_sel,
           fifo_wenable, col_idx, err
  );

  // Sequencer side
  modport slave (
    input  sample_load_en, new_row, coeff_load_en, fifo_count, result_ready,
    output modwait, sample_shift, convolve_en, coeff_ld, coeff_sel,
           fifo_wenable, col_idx, err
  );
endinterface
`default_nettype wire

// File: rtl/conv_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_sequencer
//  Description : Sequences coefficient loads, sample column shifts and
//                convolution issue for the 3x3 convolver. Tracks results in
//                flight so issue never outruns result FIFO space.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_sequencer #(
  parameter int IMG_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  conv_window_sequencer_if.slave  bus
);
  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] COL_WIN  = CW'(3);
  localparam logic [FW:0]   CREDITS  = (FW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LDCOEF = 2'd1,
    S_SHIFT  = 2'd2,
    S_ISSUE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_idx_q, col_idx_d;
  logic [1:0]    coeff_sel_q, coeff_sel_d;
  logic [FW-1:0] inflight_q, inflight_d;
  logic          modwait_q, modwait_d;
  logic          sample_shift_q, sample_shift_d;
  logic          coeff_ld_q, coeff_ld_d;
  logic          convolve_en_q, convolve_en_d;
  logic          err_q, err_d;

  logic          req;
  logic          inflight_nz;
  logic          fifo_wr;
  logic [FW:0]   committed;
  logic          has_credit;

  assign req         = bus.sample_load_en | bus.coeff_load_en;
  assign inflight_nz = (inflight_q != '0);
  assign fifo_wr     = bus.result_ready & inflight_nz;
  // Credit counts both stored results and those still inside the tree.
  assign committed   = {1'b0, bus.fifo_count} + {1'b0, inflight_q};
  assign has_credit  = (committed < CREDITS);

  // Next-state, column/coefficient bookkeeping and next registered outputs.
  // convolve_en is decided at the edge so it is a clean flop output; a stall
  // that clears therefore shows convolve_en on the cycle after credit frees.
  always_comb begin
    state_d       = state_q;
    col_idx_d     = col_idx_q;
    coeff_sel_d   = coeff_sel_q;
    convolve_en_d = 1'b0;
    err_d         = bus.result_ready & ~inflight_nz;

    case (state_q)
      S_IDLE: begin
        if (bus.coeff_load_en) begin
          state_d = S_LDCOEF;
          if (bus.sample_load_en) err_d = 1'b1;
        end else if (bus.sample_load_en) begin
          if (bus.new_row) begin
            col_idx_d = CW'(1);
            state_d   = S_SHIFT;
          end else if (col_idx_q == COL_MAX) begin
            err_d = 1'b1;
          end else begin
            col_idx_d = col_idx_q + CW'(1);
            state_d   = S_SHIFT;
          end
        end
      end
      S_LDCOEF: begin
        coeff_sel_d = (coeff_sel_q == 2'd2) ? 2'd0 : coeff_sel_q + 2'd1;
        state_d     = S_IDLE;
      end
      S_SHIFT: begin
        if (col_idx_q >= COL_WIN) begin
          state_d       = S_ISSUE;
          convolve_en_d = has_credit;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (convolve_en_q) state_d = S_IDLE;
        else               convolve_en_d = has_credit;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && req) err_d = 1'b1;

    modwait_d      = (state_d != S_IDLE);
    sample_shift_d = (state_d == S_SHIFT);
    coeff_ld_d     = (state_d == S_LDCOEF);

    // Issue and retire in the same cycle cancel out.
    inflight_d = inflight_q + FW'(convolve_en_q) - FW'(fifo_wr);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= S_IDLE;
      col_idx_q      <= '0;
      coeff_sel_q    <= 2'd0;
      inflight_q     <= '0;
      modwait_q      <= 1'b0;
      sample_shift_q <= 1'b0;
      coeff_ld_q     <= 1'b0;
      convolve_en_q  <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_idx_q      <= col_idx_d;
      coeff_sel_q    <= coeff_sel_d;
      inflight_q     <= inflight_d;
      modwait_q      <= modwait_d;
      sample_shift_q <= sample_shift_d;
      coeff_ld_q     <= coeff_ld_d;
      convolve_en_q  <= convolve_en_d;
      err_q          <= err_d;
    end
  end

  assign bus.modwait      = modwait_q;
  assign bus.sample_shift = sample_shift_q;
  assign bus.convolve_en  = convolve_en_q;
  assign bus.coeff_ld     = coeff_ld_q;
  assign bus.coeff_sel    = coeff_sel_q;
  assign bus.fifo_wenable = fifo_wr;
  assign bus.col_idx      = col_idx_q;
  assign bus.err          = err_q;
endmodule
`default_nettype wire

// File: tb/tb_conv_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_sequencer
//  Description : Directed scenarios plus randomized traffic for the convolver
//                window sequencer, checked against a request-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_sequencer;
  localparam int W = 16;
  localparam int D = 8;

  logic clk;
  logic n_rst;
  int   n_cmp;
  int   n_bad;
  bit   chk_on;

  conv_window_sequencer_if #(.IMG_WIDTH(W), .FIFO_DEPTH(D)) bus ();

  conv_window_sequencer #(.IMG_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- request-level reference model ----------------
  // Outputs expected for the cycle that follows each edge.
  int m_col, m_sel, m_inflight;
  bit m_pending;                 // a full window awaits its convolution
  bit e_modwait, e_shift, e_conv, e_cld, e_err;
  bit busy, req, wen, n_shift, n_cld, n_conv, n_err;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_col = 0; m_sel = 0; m_inflight = 0; m_pending = 0;
      e_modwait = 0; e_shift = 0; e_conv = 0; e_cld = 0; e_err = 0;
    end else begin
      busy    = e_modwait;
      req     = bus.sample_load_en || bus.coeff_load_en;
      wen     = bus.result_ready && (m_inflight != 0);
      n_err   = bus.result_ready && (m_inflight == 0);
      n_shift = 0; n_cld = 0; n_conv = 0;
      if (busy && req) n_err = 1;
      if (e_cld) m_sel = (m_sel + 1) % 3;
      if (!busy) begin
        if (bus.coeff_load_en) begin
          n_cld = 1;
          if (bus.sample_load_en) n_err = 1;
        end else if (bus.sample_load_en) begin
          if (bus.new_row)   begin m_col = 1; n_shift = 1; end
          else if (m_col == W) n_err = 1;
          else               begin m_col = m_col + 1; n_shift = 1; end
          if (n_shift && m_col >= 3) m_pending = 1;
        end
      end else if (m_pending && !n_shift) begin
        if (int'(bus.fifo_count) + m_inflight < D) begin
          n_conv = 1; m_pending = 0;
        end
      end
      m_inflight = m_inflight + (e_conv ? 1 : 0) - (wen ? 1 : 0);
      e_shift   = n_shift;
      e_cld     = n_cld;
      e_conv    = n_conv;
      e_err     = n_err;
      e_modwait = n_shift || n_cld || n_conv || m_pending;
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (n_rst && chk_on) begin
      cmp("modwait",      32'(bus.modwait),      32'(e_modwait));
      cmp("sample_shift", 32'(bus.sample_shift), 32'(e_shift));
      cmp("convolve_en",  32'(bus.convolve_en),  32'(e_conv));
      cmp("coeff_ld",     32'(bus.coeff_ld),     32'(e_cld));
      cmp("coeff_sel",    32'(bus.coeff_sel),    32'(m_sel));
      cmp("col_idx",      32'(bus.col_idx),      32'(m_col));
      cmp("err",          32'(bus.err),          32'(e_err));
      cmp("fifo_wenable", 32'(bus.fifo_wenable),
          32'(bus.result_ready && (m_inflight != 0)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    bus.sample_load_en = 0;
    bus.new_row        = 0;
    bus.coeff_load_en  = 0;
  endtask

  task automatic do_sample(input bit nr);
    int i;
    bus.sample_load_en = 1;
    bus.new_row        = nr;
    tick();
    clr();
    for (i = 0; i < 12; i++) begin
      if (!bus.modwait) break;
      tick();
    end
    if (i == 12) cmp("sample_done_timeout", 32'(bus.modwait), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_on = 0;
    n_rst = 0;
    clr();
    bus.fifo_count   = '0;
    bus.result_ready = 0;
    repeat (3) tick();
    cmp("rst_modwait", 32'(bus.modwait), 0);
    cmp("rst_col",     32'(bus.col_idx), 0);
    cmp("rst_sel",     32'(bus.coeff_sel), 0);
    n_rst = 1; chk_on = 1;
    tick();

    // T2: three coefficient loads four cycles apart, then wrap
    for (int k = 0; k < 3; k++) begin
      bus.coeff_load_en = 1;
      tick();
      clr();
      cmp("t2_coeff_ld", 32'(bus.coeff_ld), 1);
      cmp("t2_sel",      32'(bus.coeff_sel), 32'(k));
      cmp("t2_modwait",  32'(bus.modwait), 1);
      tick();
      cmp("t2_idle",     32'(bus.modwait), 0);
      tick(); tick();
    end
    cmp("t2_wrap", 32'(bus.coeff_sel), 0);

    // T3: new row plus two loads; convolve only after the third
    bus.sample_load_en = 1; bus.new_row = 1;
    tick(); clr();
    cmp("t3_shift1", 32'(bus.sample_shift), 1);
    cmp("t3_col1",   32'(bus.col_idx), 1);
    tick();
    cmp("t3_nowait1", 32'(bus.modwait), 0);
    cmp("t3_noconv1", 32'(bus.convolve_en), 0);
    bus.sample_load_en = 1;
    tick(); clr();
    cmp("t3_col2", 32'(bus.col_idx), 2);
    tick();
    cmp("t3_noconv2", 32'(bus.convolve_en), 0);
    bus.sample_load_en = 1;
    tick(); clr();
    cmp("t3_shift3", 32'(bus.sample_shift), 1);
    cmp("t3_col3",   32'(bus.col_idx), 3);
    cmp("t3_conv_n1", 32'(bus.convolve_en), 0);
    tick();
    cmp("t3_conv_n2", 32'(bus.convolve_en), 1);
    cmp("t3_busy_n2", 32'(bus.modwait), 1);
    tick();
    cmp("t3_done", 32'(bus.modwait), 0);
    bus.result_ready = 1; #1;
    cmp("t3_wen", 32'(bus.fifo_wenable), 1);
    tick();
    bus.result_ready = 0;

    // T4: full FIFO stalls issue until a slot frees
    bus.fifo_count = 4'd8;
    bus.sample_load_en = 1;
    tick(); clr();
    cmp("t4_col4", 32'(bus.col_idx), 4);
    tick();
    cmp("t4_stall_conv", 32'(bus.convolve_en), 0);
    cmp("t4_stall_wait", 32'(bus.modwait), 1);
    tick();
    cmp("t4_stall_conv2", 32'(bus.convolve_en), 0);
    bus.fifo_count = 4'd7;
    tick();
    cmp("t4_release", 32'(bus.convolve_en), 1);
    tick();
    cmp("t4_idle", 32'(bus.modwait), 0);
    bus.fifo_count = '0;
    bus.result_ready = 1;
    tick();
    bus.result_ready = 0;

    // T5: request while busy, then coeff and sample together
    bus.sample_load_en = 1;
    tick();
    cmp("t5_shift", 32'(bus.sample_shift), 1);
    tick(); clr();
    cmp("t5_err",     32'(bus.err), 1);
    cmp("t5_noshift", 32'(bus.sample_shift), 0);
    cmp("t5_col",     32'(bus.col_idx), 5);
    tick();
    cmp("t5_err_clr", 32'(bus.err), 0);
    bus.coeff_load_en = 1; bus.sample_load_en = 1;
    tick(); clr();
    cmp("t5_both_cld",   32'(bus.coeff_ld), 1);
    cmp("t5_both_err",   32'(bus.err), 1);
    cmp("t5_both_shift", 32'(bus.sample_shift), 0);
    cmp("t5_both_col",   32'(bus.col_idx), 5);
    tick();

    // T6: stray result, then column saturation
    bus.result_ready = 1; #1;
    cmp("t6_wen_live", 32'(bus.fifo_wenable), 1);
    tick(); #1;
    cmp("t6_wen_none", 32'(bus.fifo_wenable), 0);
    tick();
    cmp("t6_err_rr", 32'(bus.err), 1);
    bus.result_ready = 0;
    tick();
    bus.result_ready = 1;
    do_sample(1);
    for (int c = 0; c < 15; c++) do_sample(0);
    bus.result_ready = 0;
    tick(); tick();
    cmp("t6_col16", 32'(bus.col_idx), 16);
    bus.sample_load_en = 1;
    tick(); clr();
    cmp("t6_sat_err",   32'(bus.err), 1);
    cmp("t6_sat_shift", 32'(bus.sample_shift), 0);
    cmp("t6_sat_col",   32'(bus.col_idx), 16);
    cmp("t6_sat_wait",  32'(bus.modwait), 0);
    tick();

    // T1: reset in the middle of an issue stall
    bus.fifo_count = 4'd8;
    do_sample(1);
    do_sample(0);
    bus.sample_load_en = 1;
    tick(); clr();
    tick(); tick();
    cmp("t1_stalled", 32'(bus.modwait), 1);
    bus.result_ready = 1;
    n_rst = 0; #1;
    cmp("t1_modwait", 32'(bus.modwait), 0);
    cmp("t1_shift",   32'(bus.sample_shift), 0);
    cmp("t1_conv",    32'(bus.convolve_en), 0);
    cmp("t1_cld",     32'(bus.coeff_ld), 0);
    cmp("t1_sel",     32'(bus.coeff_sel), 0);
    cmp("t1_wen",     32'(bus.fifo_wenable), 0);
    cmp("t1_col",     32'(bus.col_idx), 0);
    cmp("t1_err",     32'(bus.err), 0);
    bus.result_ready = 0;
    bus.fifo_count = '0;
    tick(); tick();
    n_rst = 1;
    tick();
    cmp("t1_idle", 32'(bus.modwait), 0);
    bus.coeff_load_en = 1;
    tick(); clr();
    cmp("t1_accept", 32'(bus.coeff_ld), 1);
    cmp("t1_sel0",   32'(bus.coeff_sel), 0);
    tick();

    // Randomized traffic, including protocol violations and async resets
    for (int n = 0; n < 3000; n++) begin
      bus.sample_load_en = ($urandom_range(0, 99) < 30);
      bus.new_row        = ($urandom_range(0, 99) < 15);
      bus.coeff_load_en  = ($urandom_range(0, 99) < 10);
      bus.result_ready   = ($urandom_range(0, 99) < 25);
      if ($urandom_range(0, 9) == 0) bus.fifo_count = 4'($urandom_range(0, 8));
      if ($urandom_range(0, 499) == 0) begin
        n_rst = 0;
        tick();
        n_rst = 1;
      end
      tick();
    end
    clr();
    bus.result_ready = 0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
